room_occupancy_sequencer: RTL and testbench

Sequences the room light from two door beam sensors. Syncs and debounces the sensors, then decodes pass direction with a state machine. Keeps a saturating occupant count and drives the light with an off-delay hold. Sits between the raw door sensors and the light driver; it is the single owner of the light output.

---
 rtl/room_occupancy_sequencer.sv | 128 ++++++++++++
 tb/tb_room_occupancy_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/room_occupancy_sequencer.sv
// Door-beam occupancy sequencer: sync + debounce two beams, decode pass direction,
// keep a saturating occupant count and drive the light with an off-delay hold.
module room_occupancy_sequencer #(
   parameter int CNT_W       = 8,
   parameter int MAX_OCC     = 200,
   parameter int DB_CYCLES   = 4,
   parameter int OFF_DELAY   = 1000,
   parameter int SEQ_TIMEOUT = 5000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             s1_i,
   input  logic             s2_i,
   output logic             light_o,
   output logic [CNT_W-1:0] occupancy_o,
   output logic             full_o,
   output logic             entry_pulse_o,
   output logic             exit_pulse_o,
   output logic             seq_error_o
);
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int TW  = $clog2(SEQ_TIMEOUT + 1);
   localparam int HW  = $clog2(OFF_DELAY + 1);

   typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR} state_t;

   // Bit 1 carries the outer beam (s1), bit 0 the inner beam (s2).
   logic [1:0]          meta_q, sync_q, deb_q;
   logic [1:0][DBW-1:0] db_cnt_q;
   state_t              state_q, state_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [CNT_W-1:0]    occ_d;
   logic                entry_d, exit_d, err_d, bad, in_pass;

   always_comb begin
      state_d = state_q;
      entry_d = 1'b0;
      exit_d  = 1'b0;
      err_d   = 1'b0;
      bad     = 1'b0;
      in_pass = (state_q != IDLE) && (state_q != WAIT_CLR);
      case (state_q)
         IDLE: case (deb_q)
            2'b10: state_d = EN1;
            2'b01: state_d = EX1;
            2'b11: begin state_d = WAIT_CLR; err_d = 1'b1; end
            default: ;
         endcase
         EN1: if (deb_q == 2'b11) state_d = EN2;
              else if (deb_q == 2'b00) state_d = IDLE;
              else if (deb_q != 2'b10) bad = 1'b1;
         EN2: if (deb_q == 2'b01) state_d = EN3;
              else if (deb_q == 2'b10) state_d = EN1;
              else if (deb_q != 2'b11) bad = 1'b1;
         EN3: if (deb_q == 2'b00) begin state_d = IDLE; entry_d = 1'b1; end
              else if (deb_q == 2'b11) state_d = EN2;
              else if (deb_q != 2'b01) bad = 1'b1;
         EX1: if (deb_q == 2'b11) state_d = EX2;
              else if (deb_q == 2'b00) state_d = IDLE;
              else if (deb_q != 2'b01) bad = 1'b1;
         EX2: if (deb_q == 2'b10) state_d = EX3;
              else if (deb_q == 2'b01) state_d = EX1;
              else if (deb_q != 2'b11) bad = 1'b1;
         EX3: if (deb_q == 2'b00) begin state_d = IDLE; exit_d = 1'b1; end
              else if (deb_q == 2'b11) state_d = EX2;
              else if (deb_q != 2'b10) bad = 1'b1;
         default: if (deb_q == 2'b00) state_d = IDLE;
      endcase
      // A stalled partial pass aborts after SEQ_TIMEOUT cycles in the same state.
      if (bad || (in_pass && state_d == state_q && tmo_q == TW'(SEQ_TIMEOUT - 1))) begin
         state_d = WAIT_CLR;
         err_d   = 1'b1;
      end
      tmo_d = (state_d != state_q || !in_pass) ? '0 : tmo_q + 1'b1;

      occ_d = occupancy_o;
      if (entry_d && occupancy_o != CNT_W'(MAX_OCC)) occ_d = occupancy_o + 1'b1;
      else if (exit_d && occupancy_o != '0)          occ_d = occupancy_o - 1'b1;

      if (entry_d)                                 hold_d = '0;
      else if (occupancy_o != '0 && occ_d == '0)   hold_d = HW'(OFF_DELAY);
      else if (hold_q != '0)                       hold_d = hold_q - 1'b1;
      else                                         hold_d = hold_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         meta_q        <= '0;
         sync_q        <= '0;
         deb_q         <= '0;
         db_cnt_q      <= '0;
         state_q       <= IDLE;
         tmo_q         <= '0;
         hold_q        <= '0;
         light_o       <= 1'b0;
         occupancy_o   <= '0;
         full_o        <= 1'b0;
         entry_pulse_o <= 1'b0;
         exit_pulse_o  <= 1'b0;
         seq_error_o   <= 1'b0;
      end else begin
         meta_q <= {s1_i, s2_i};
         sync_q <= meta_q;
         for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != deb_q[i]) begin
               if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                  deb_q[i]    <= sync_q[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         hold_q        <= hold_d;
         occupancy_o   <= occ_d;
         full_o        <= (occ_d == CNT_W'(MAX_OCC));
         light_o       <= (occ_d != '0) || (hold_d != '0);
         entry_pulse_o <= entry_d;
         exit_pulse_o  <= exit_d;
         seq_error_o   <= err_d;
      end
   end
endmodule

// File: tb/tb_room_occupancy_sequencer.sv
// Directed bench for room_occupancy_sequencer with default parameters.
module tb_room_occupancy_sequencer;
   logic       clk = 1'b0, reset = 1'b1, s1 = 1'b0, s2 = 1'b0;
   logic       light, full, entry_pulse, exit_pulse, seq_error;
   logic [7:0] occupancy;
   int checks = 0, failures = 0;

   room_occupancy_sequencer dut (
      .clk_i(clk), .reset_i(reset), .s1_i(s1), .s2_i(s2),
      .light_o(light), .occupancy_o(occupancy), .full_o(full),
      .entry_pulse_o(entry_pulse), .exit_pulse_o(exit_pulse), .seq_error_o(seq_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ent_n = 0, ext_n = 0, err_n = 0, fall_n = 0;
   int ent_cyc = 0, ext_cyc = 0, err_cyc = 0, fall_cyc = 0;
   int occ_at_ent = 0, light_at_ent = 0;
   logic light_prev = 1'b0;
   always @(negedge clk) begin
      if (entry_pulse) begin ent_n++; ent_cyc = cyc; occ_at_ent = occupancy; light_at_ent = light; end
      if (exit_pulse) begin ext_n++; ext_cyc = cyc; end
      if (seq_error) begin err_n++; err_cyc = cyc; end
      if (light_prev && !light) begin fall_n++; fall_cyc = cyc; end
      light_prev = light;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic a, input logic b, input int n);
      s1 = a; s2 = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_entry(input int n);
      drive(1, 0, n); drive(1, 1, n); drive(0, 1, n); drive(0, 0, n);
   endtask

   task automatic do_exit(input int n);
      drive(0, 1, n); drive(1, 1, n); drive(1, 0, n); drive(0, 0, n);
   endtask

   task automatic wait_fall(input int base);
      for (int i = 0; i < 1200 && fall_n == base; i++) @(negedge clk);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int e0, x0, r0, f0, c0;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {light, occupancy, full, entry_pulse, exit_pulse, seq_error}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Clean entry with latency measured from the final 00 step.
      e0 = ent_n; r0 = err_n;
      drive(1, 0, 20); drive(1, 1, 20); drive(0, 1, 20);
      c0 = cyc;
      drive(0, 0, 20);
      check("entry_count", ent_n - e0, 1);
      check("entry_latency", ent_cyc - c0, 7);
      check("occ_at_entry_edge", occ_at_ent, 1);
      check("light_at_entry_edge", light_at_ent, 1);
      check("entry_no_error", err_n - r0, 0);

      // Clean exit, then the light hold is exactly OFF_DELAY cycles.
      x0 = ext_n; f0 = fall_n;
      do_exit(20);
      check("exit_count", ext_n - x0, 1);
      check("occ_after_exit", occupancy, 0);
      check("light_held", light, 1);
      wait_fall(f0);
      check("hold_len", fall_cyc - ext_cyc, 1000);

      // Re-entry midway through the hold keeps the light on.
      do_entry(20);
      do_exit(20);
      f0 = fall_n;
      repeat (400) @(negedge clk);
      do_entry(20);
      check("reentry_no_fall", fall_n - f0, 0);
      check("reentry_occ", occupancy, 1);
      check("reentry_light", light, 1);
      do_exit(20);
      f0 = fall_n;
      wait_fall(f0);
      check("hold_len2", fall_cyc - ext_cyc, 1000);

      // Backout: 10,11,10,00 produces nothing.
      e0 = ent_n; x0 = ext_n; r0 = err_n;
      drive(1, 0, 20); drive(1, 1, 20); drive(1, 0, 20); drive(0, 0, 20);
      check("backout_pulses", (ent_n - e0) + (ext_n - x0) + (err_n - r0), 0);
      check("backout_occ", occupancy, 0);

      // Short glitch on s2 is filtered.
      drive(0, 1, 3); drive(0, 0, 20);
      check("glitch_pulses", (ent_n - e0) + (ext_n - x0) + (err_n - r0), 0);

      // Simultaneous rise is one error, wait until clear, no count.
      drive(1, 1, 20); drive(0, 1, 20); drive(1, 1, 20);
      check("simul_err", err_n - r0, 1);
      drive(0, 0, 20);
      check("simul_no_count", (ent_n - e0) + (ext_n - x0), 0);

      // Stalled pass times out once.
      r0 = err_n;
      c0 = cyc;
      drive(1, 0, 6000);
      check("timeout_err", err_n - r0, 1);
      check("timeout_cycle", err_cyc - c0, 5007);
      drive(0, 0, 20);
      check("timeout_no_count", (ent_n - e0) + (ext_n - x0), 0);
      check("timeout_recover_err", err_n - r0, 1);

      // Exit at zero still pulses, count holds at 0.
      x0 = ext_n;
      do_exit(20);
      check("exit_at_zero", ext_n - x0, 1);
      check("occ_floor", occupancy, 0);

      // Saturation at MAX_OCC.
      e0 = ent_n;
      for (int i = 0; i < 199; i++) do_entry(10);
      check("occ_199", occupancy, 199);
      check("full_199", full, 0);
      do_entry(10);
      do_entry(10);
      check("sat_pulses", ent_n - e0, 201);
      check("occ_sat", occupancy, 200);
      check("full_sat", full, 1);

      // Reset in the middle of a pass with occupancy 5.
      reset_pulse();
      for (int i = 0; i < 5; i++) do_entry(12);
      check("occ_five", occupancy, 5);
      drive(1, 0, 20); drive(1, 1, 20);
      #1 reset = 1'b1;
      #1 check("midpass_reset", {light, occupancy, full, entry_pulse, exit_pulse, seq_error}, 0);
      s1 = 1'b0; s2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      r0 = err_n;
      do_entry(20);
      check("post_reset_occ", occupancy, 1);
      check("post_reset_err", err_n - r0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
